// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity modes and the
// parity helper used by both directions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Data is zero-extended to 9 bits; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PARITY_ODD) begin
      parity_bit = ~p;
    end else begin
      parity_bit = p;
    end
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the receiver: two-flop synchroniser plus a three-tap majority voter over
// consecutive oversample ticks.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic rx,
  output logic voted,
  output logic fall_hint
);

  logic       sync1_r;
  logic       sync2_r;
  logic [1:0] hist_r;

  // Synchronise rx every clk and keep the samples of the two previous ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      hist_r  <= 2'b11;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      if (clk_en) begin
        hist_r <= {hist_r[0], sync2_r};
      end
    end
  end

  // On a tick, sync2_r is the current sample and hist_r holds the two before it.
  assign voted     = (hist_r[1] & hist_r[0]) | (hist_r[1] & sync2_r) | (hist_r[0] & sync2_r);
  assign fall_hint = ~sync2_r;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receive engine: start validation, LSB-first data, optional parity,
// one or two checked stop bits, with parity/framing/overrun/break reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 brk,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] MID_HI   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_state_e          state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [BIT_W-1:0]     bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;
  logic                 par_err_acc_r;
  logic                 frame_acc_r;

  logic voted_s;
  logic fall_hint_s;
  logic complete_s;
  logic frame_new_s;
  logic brk_new_s;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .rx        (rx),
    .voted     (voted_s),
    .fall_hint (fall_hint_s)
  );

  // Completing half a bit into the last stop bit leaves time to catch a back-to-back start.
  assign complete_s  = clk_en & (state_r == ST_STOP) & (cnt_r == MID_HI) & (bit_idx_r == STOP_LAST);
  assign frame_new_s = frame_acc_r | ~voted_s;
  assign brk_new_s   = frame_new_s & (shift_r == '0) & ~par_bit_r;

  // Receive FSM, shift register and host-visible flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      bit_idx_r     <= '0;
      shift_r       <= '0;
      par_bit_r     <= 1'b0;
      par_err_acc_r <= 1'b0;
      frame_acc_r   <= 1'b0;
      data_out      <= '0;
      rdy           <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      brk           <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (clk_en) begin
        case (state_r)
          ST_IDLE: begin
            if (fall_hint_s) begin
              state_r       <= ST_START;
              busy          <= 1'b1;
              cnt_r         <= '0;
              par_bit_r     <= 1'b0;
              par_err_acc_r <= 1'b0;
              frame_acc_r   <= 1'b0;
            end
          end
          ST_START: begin
            if (cnt_r == MID_HI && voted_s) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              cnt_r   <= '0;
            end else if (cnt_r == CNT_LAST) begin
              state_r   <= ST_DATA;
              cnt_r     <= '0;
              bit_idx_r <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (cnt_r == MID_HI) begin
              shift_r   <= {voted_s, shift_r[DATA_BITS-1:1]};
              bit_idx_r <= bit_idx_r + BIT_W'(1);
            end
            if (cnt_r == CNT_LAST) begin
              cnt_r <= '0;
              if (bit_idx_r == BIT_LAST) begin
                state_r   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                bit_idx_r <= '0;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_PARITY: begin
            if (cnt_r == MID_HI) begin
              par_bit_r     <= voted_s;
              par_err_acc_r <= voted_s != parity_bit(9'(shift_r), PARITY_MODE);
            end
            if (cnt_r == CNT_LAST) begin
              state_r   <= ST_STOP;
              cnt_r     <= '0;
              bit_idx_r <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_STOP: begin
            if (complete_s) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              cnt_r   <= '0;
            end else begin
              if (cnt_r == MID_HI && !voted_s) begin
                frame_acc_r <= 1'b1;
              end
              if (cnt_r == CNT_LAST) begin
                cnt_r     <= '0;
                bit_idx_r <= bit_idx_r + BIT_W'(1);
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            cnt_r   <= '0;
          end
        endcase
      end

      // A frame completing alongside a host read wins: rdy stays up with fresh flags.
      if (complete_s) begin
        data_out   <= shift_r;
        rdy        <= 1'b1;
        parity_err <= par_err_acc_r;
        frame_err  <= frame_new_s;
        brk        <= brk_new_s;
        overrun    <= (overrun | rdy) & ~rdy_clr;
      end else if (rdy_clr) begin
        rdy        <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
        brk        <= 1'b0;
      end
    end
  end

endmodule
